// File: rtl/dma_rd_burst_gen_pkg.sv
// Shared DMA header: bus widths, the AXI 4 KB boundary and the read-generator state encoding.
package dma_rd_burst_gen_pkg;

  localparam int unsigned DDR_ADDR_W   = 32;
  localparam int unsigned MIG_BUS_W    = 256;
  localparam int unsigned AXI_LEN_W    = 8;
  localparam int unsigned AXI_4K_BYTES = 4096;

  typedef enum logic [1:0] {
    RgIdle  = 2'd0,
    RgCalc  = 2'd1,
    RgBurst = 2'd2
  } rg_state_e;

endpackage

// File: rtl/dma_burst_len_calc.sv
// Burst sizing: min(remaining beats, beat cap, beats left before the next 4 KB boundary) - 1.
// Combinational; shared between the read and write burst generators.
module dma_burst_len_calc
  import dma_rd_burst_gen_pkg::*;
#(
  parameter int unsigned CNT_W     = 20,
  parameter int unsigned LEN_W     = 8,
  parameter int unsigned SZ        = 5,
  parameter int unsigned MAX_BEATS = 256
) (
  input  logic [11:0]      addr_lo_i,
  input  logic [CNT_W-1:0] rem_i,
  output logic [LEN_W-1:0] len_o
);

  // Wide enough for rem, the 4096-byte distance and a full 2^LEN_W beat count.
  localparam int unsigned W0 = (CNT_W > 13) ? CNT_W : 13;
  localparam int unsigned CW = (W0 > LEN_W + 1) ? W0 : LEN_W + 1;

  logic [CW-1:0] to4k;
  logic [CW-1:0] burst;

  // Minimum of the three limits; rem is never zero when this result is used.
  always_comb begin
    to4k  = (CW'(AXI_4K_BYTES) - CW'(addr_lo_i)) >> SZ;
    burst = CW'(rem_i);
    if (burst > CW'(MAX_BEATS)) burst = CW'(MAX_BEATS);
    if (burst > to4k)           burst = to4k;
    len_o = LEN_W'(burst - CW'(1));
  end

endmodule

// File: rtl/dma_rd_burst_gen.sv
// Read-command splitter: cuts one linear read into 4 KB-safe INCR bursts for the AXI read
// engine and forwards returned beats as a registered stream, flagging the command's last beat.
module dma_rd_burst_gen
  import dma_rd_burst_gen_pkg::*;
#(
  parameter int unsigned ADDR_W    = DDR_ADDR_W,
  parameter int unsigned DATA_W    = MIG_BUS_W,
  parameter int unsigned LEN_W     = AXI_LEN_W,
  parameter int unsigned CNT_W     = 20,
  parameter int unsigned MAX_BEATS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [CNT_W-1:0]  cmd_nbeats,
  input  logic              pause,
  output logic              busy,
  output logic              done,
  output logic              dma_valid,
  output logic [ADDR_W-1:0] dma_addr,
  output logic [LEN_W-1:0]  dma_len,
  input  logic              dma_ready,
  input  logic [DATA_W-1:0] dma_rdata,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned SZ    = $clog2(BYTES);
  localparam logic [ADDR_W-1:0] AddrMask = ~ADDR_W'(BYTES - 1);

  rg_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic              done_q, done_d;

  logic [LEN_W-1:0]  calc_len;
  logic [CNT_W-1:0]  burst_beats;
  logic [ADDR_W-1:0] burst_bytes;
  logic              final_burst;

  dma_burst_len_calc #(
    .CNT_W    (CNT_W),
    .LEN_W    (LEN_W),
    .SZ       (SZ),
    .MAX_BEATS(MAX_BEATS)
  ) u_len_calc (
    .addr_lo_i(addr_q[11:0]),
    .rem_i    (rem_q),
    .len_o    (calc_len)
  );

  assign burst_beats = CNT_W'(len_q) + CNT_W'(1);
  assign burst_bytes = (ADDR_W'(len_q) + ADDR_W'(1)) << SZ;
  assign final_burst = (rem_q == burst_beats);

  // Next-state: command latch, burst sizing, beat counting and stream capture.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    len_d       = len_q;
    beat_cnt_d  = beat_cnt_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_last_d  = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      RgIdle: begin
        if (cmd_valid) begin
          addr_d = cmd_addr & AddrMask;
          rem_d  = cmd_nbeats;
          if (cmd_nbeats == '0) done_d = 1'b1;
          else                  state_d = RgCalc;
        end
      end
      RgCalc: begin
        len_d      = calc_len;
        beat_cnt_d = '0;
        if (!pause) state_d = RgBurst;
      end
      RgBurst: begin
        if (dma_ready) begin
          beat_cnt_d  = beat_cnt_q + LEN_W'(1);
          out_valid_d = 1'b1;
          out_data_d  = dma_rdata;
          if (beat_cnt_q == len_q) begin
            addr_d     = addr_q + burst_bytes;
            rem_d      = rem_q - burst_beats;
            out_last_d = final_burst;
            if (final_burst) begin
              state_d = RgIdle;
              done_d  = 1'b1;
            end else begin
              state_d = RgCalc;
            end
          end
        end
      end
      default: state_d = RgIdle;
    endcase
  end

  // State and datapath registers; reset aborts any burst in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RgIdle;
      addr_q      <= '0;
      rem_q       <= '0;
      len_q       <= '0;
      beat_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      len_q       <= len_d;
      beat_cnt_q  <= beat_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  // Request decoded from registered state so it drops the cycle after a burst's last beat.
  assign dma_valid = (state_q == RgBurst);
  assign dma_addr  = addr_q;
  assign dma_len   = len_q;
  assign busy      = (state_q != RgIdle);
  // Gated by reset so every output reads 0 while reset is held.
  assign cmd_ready = (state_q == RgIdle) && rst;
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_dma_rd_burst_gen.sv
// Bench for dma_rd_burst_gen: directed scenarios plus random commands, with a read-engine
// model supplying beats and an arithmetic burst-split reference model.
module tb_dma_rd_burst_gen;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned DATA_W    = 256;
  localparam int unsigned LEN_W     = 8;
  localparam int unsigned CNT_W     = 20;
  localparam int unsigned MAX_BEATS = 256;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [CNT_W-1:0]  cmd_nbeats = '0;
  logic              pause = 1'b0;
  logic              busy, done, dma_valid;
  logic [ADDR_W-1:0] dma_addr;
  logic [LEN_W-1:0]  dma_len;
  logic              dma_ready;
  logic [DATA_W-1:0] dma_rdata;
  logic              out_valid, out_last;
  logic [DATA_W-1:0] out_data;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Engine-model bookkeeping
  int                start_q[$];
  int                last_q[$];
  logic [31:0]       baddr_q[$];
  logic [7:0]        blen_q[$];
  logic [DATA_W-1:0] data_q[$];
  bit                eng_active = 0;
  bit                eng_stall = 0;
  bit                eng_spurious = 0;
  int                eng_left = 0;
  int                eng_beats = 0;
  logic [31:0]       cur_addr;
  logic [7:0]        cur_len;

  logic [31:0] ra;
  int          rn;
  bit          rst_hit;

  dma_rd_burst_gen #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .LEN_W    (LEN_W),
    .CNT_W    (CNT_W),
    .MAX_BEATS(MAX_BEATS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_nbeats(cmd_nbeats),
    .pause     (pause),
    .busy      (busy),
    .done      (done),
    .dma_valid (dma_valid),
    .dma_addr  (dma_addr),
    .dma_len   (dma_len),
    .dma_ready (dma_ready),
    .dma_rdata (dma_rdata),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rnd256();
    logic [DATA_W-1:0] v;
    for (int i = 0; i < DATA_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Read-engine model: acts on the falling edge, accepts a burst on dma_valid, returns len+1
  // beats (optionally with random stalls) and records what it saw.
  initial begin
    dma_ready = 1'b0;
    dma_rdata = '0;
    forever begin
      @(negedge clk);
      dma_ready = 1'b0;
      if (!rst) begin
        eng_active = 0;
        data_q.delete();
      end else begin
        if (eng_active) begin
          chk("burst_valid_held", dma_valid, 1);
          chk("burst_addr_held", dma_addr, cur_addr);
          chk("burst_len_held", dma_len, cur_len);
        end else if (dma_valid) begin
          eng_active = 1;
          eng_left   = int'(dma_len) + 1;
          cur_addr   = dma_addr;
          cur_len    = dma_len;
          start_q.push_back(cyc);
          baddr_q.push_back(dma_addr);
          blen_q.push_back(dma_len);
        end else if (eng_spurious) begin
          dma_ready = 1'b1;
          dma_rdata = rnd256();
        end
        if (eng_active && !(eng_stall && $urandom_range(0, 3) == 0)) begin
          dma_ready = 1'b1;
          dma_rdata = rnd256();
          data_q.push_back(dma_rdata);
          eng_left--;
          eng_beats++;
          if (eng_left == 0) begin
            eng_active = 0;
            last_q.push_back(cyc);
          end
        end
      end
    end
  end

  // One command end to end, checked against an arithmetic split of the command.
  task automatic run_cmd(input logic [31:0] addr, input int n, input bit stall,
                         input int pause_at, input int hold);
    logic [31:0] a;
    logic [31:0] ea[$];
    int          el[$];
    int          rem, b, to4k, acc, beats, hold_cnt, rel_cyc;
    bit          got_done, psd;
    a   = addr & 32'hFFFF_FFE0;
    rem = n;
    while (rem > 0) begin
      to4k = (4096 - int'(a[11:0])) / 32;
      b = rem;
      if (b > int'(MAX_BEATS)) b = int'(MAX_BEATS);
      if (b > to4k) b = to4k;
      ea.push_back(a);
      el.push_back(b - 1);
      a   = a + 32'(b * 32);
      rem = rem - b;
    end
    start_q.delete(); last_q.delete(); baddr_q.delete(); blen_q.delete(); data_q.delete();
    eng_beats = 0;
    eng_stall = stall;
    @(negedge clk); #1;
    chk("cmd_ready_idle", cmd_ready, 1);
    chk("busy_idle", busy, 0);
    cmd_addr   = addr;
    cmd_nbeats = CNT_W'(n);
    cmd_valid  = 1'b1;
    acc        = cyc;
    @(negedge clk); #1;
    // In pause runs a junk command stays asserted while busy; it must be ignored.
    cmd_valid  = (pause_at > 0);
    cmd_addr   = 32'h5555_0000;
    cmd_nbeats = CNT_W'(7);
    chk("busy_run", busy, 1);
    beats = 0; got_done = 0; psd = 0; hold_cnt = 0; rel_cyc = 0;
    for (int i = 0; i < 20000 && !got_done; i++) begin
      if (out_valid) begin
        beats++;
        if (data_q.size() == 0) chk("beat_unexpected", out_valid, 0);
        else chk("out_data", out_data, data_q.pop_front());
        chk("out_last", out_last, beats == n);
      end else begin
        chk("last_without_valid", out_last, 0);
      end
      chk("done", done, out_valid && beats == n);
      got_done = done;
      if (pause_at > 0 && !psd && eng_beats >= pause_at) begin
        pause = 1'b1;
        psd   = 1;
      end
      if (pause && !eng_active && last_q.size() >= 1 && cyc > last_q[0]) begin
        chk("pause_hold_valid", dma_valid, 0);
        chk("pause_hold_busy", busy, 1);
        hold_cnt++;
        if (hold_cnt == hold) begin
          pause     = 1'b0;
          cmd_valid = 1'b0;
          rel_cyc   = cyc;
        end
      end
      if (!got_done) begin
        @(negedge clk); #1;
      end
    end
    cmd_valid = 1'b0;
    chk("done_seen", got_done, 1);
    chk("beat_count", beats, n);
    chk("burst_count", start_q.size(), ea.size());
    for (int k = 0; k < ea.size() && k < baddr_q.size(); k++) begin
      chk("burst_addr", baddr_q[k], ea[k]);
      chk("burst_len", blen_q[k], el[k]);
    end
    if (start_q.size() > 0) chk("cmd_latency", start_q[0] - acc, 2);
    for (int k = 1; k < start_q.size() && k <= last_q.size(); k++) begin
      if (k == 1 && pause_at > 0) chk("pause_release_gap", start_q[1] - rel_cyc, 1);
      else                        chk("burst_gap", start_q[k] - last_q[k-1], 2);
    end
    @(negedge clk); #1;
    chk("done_pulse_end", done, 0);
    chk("busy_after", busy, 0);
    chk("valid_after", dma_valid, 0);
    chk("ready_after", cmd_ready, 1);
    chk("out_valid_after", out_valid, 0);
  endtask

  initial begin
    // Power-on reset
    #12;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dma_valid", dma_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_done", done, 0);
    @(negedge clk); #1;
    rst = 1'b1;

    // Directed scenarios
    run_cmd(32'h0000_0000, 4, 0, 0, 0);
    run_cmd(32'h0000_0FC0, 4, 0, 0, 0);
    run_cmd(32'h0000_0000, 300, 0, 0, 0);
    run_cmd(32'h0000_0FDF, 3, 0, 0, 0);

    // Zero-beat command
    start_q.delete();
    @(negedge clk); #1;
    cmd_addr = 32'h40; cmd_nbeats = '0; cmd_valid = 1'b1;
    chk("zero_cmd_ready", cmd_ready, 1);
    @(negedge clk); #1;
    cmd_valid = 1'b0;
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    chk("zero_dma_valid", dma_valid, 0);
    @(negedge clk); #1;
    chk("zero_done_drop", done, 0);
    chk("zero_busy_after", busy, 0);
    chk("zero_no_burst", start_q.size(), 0);

    // Pause during the first burst, held 6 cycles in CALC
    run_cmd(32'h0000_0000, 300, 0, 10, 6);

    // Stray dma_ready while idle
    eng_spurious = 1;
    repeat (5) begin
      @(negedge clk); #1;
      chk("spurious_out_valid", out_valid, 0);
      chk("spurious_busy", busy, 0);
    end
    eng_spurious = 0;

    // Reset during beat 10 of a burst
    start_q.delete(); last_q.delete(); baddr_q.delete(); blen_q.delete(); data_q.delete();
    eng_beats = 0; eng_stall = 0; rst_hit = 0;
    @(negedge clk); #1;
    cmd_addr = 32'h0; cmd_nbeats = CNT_W'(300); cmd_valid = 1'b1;
    @(negedge clk); #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < 200 && !rst_hit; i++) begin
      @(negedge clk); #1;
      rst_hit = (eng_beats >= 10);
    end
    chk("rst_reach_beat10", rst_hit, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_dma_valid", dma_valid, 0);
    chk("mid_rst_dma_addr", dma_addr, 0);
    chk("mid_rst_dma_len", dma_len, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_out_last", out_last, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cmd_ready", cmd_ready, 0);
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b1;
    run_cmd(32'h0000_1234, 50, 0, 0, 0);

    // Address wrap at the top of the space, low bits set
    run_cmd(32'hFFFF_FF1F, 20, 0, 0, 0);

    // Random commands, alternating engine stalls
    for (int r = 0; r < 6; r++) begin
      ra = $urandom;
      rn = $urandom_range(1, 600);
      run_cmd(ra, rn, r[0], 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
